// File: rtl/writeback_stage_if.sv
// MEM->WB handshake/bus bundle for writeback_stage.
// retire_count is only present when RETIRE_CNT_EN is defined.
interface writeback_stage_if;
    logic        stall;
    logic        flush;
    logic        valid_in;
    logic [12:0] PC;
    logic [31:0] ALURes;
    logic [31:0] ReadData;
    logic        Mem_Read;
    logic        Reg_Write;
    logic [4:0]  WriteReg;
    logic        halt_in;
    logic [12:0] PCOut;
    logic [31:0] WriteData;
    logic [4:0]  WriteRegOut;
    logic        RegWriteOut;
    logic        valid_out;
    logic        halted;
`ifdef RETIRE_CNT_EN
    logic [31:0] retire_count;

    modport master (
        output stall, flush, valid_in, PC, ALURes, ReadData, Mem_Read,
               Reg_Write, WriteReg, halt_in,
        input  PCOut, WriteData, WriteRegOut, RegWriteOut, valid_out,
               halted, retire_count
    );
    modport slave (
        input  stall, flush, valid_in, PC, ALURes, ReadData, Mem_Read,
               Reg_Write, WriteReg, halt_in,
        output PCOut, WriteData, WriteRegOut, RegWriteOut, valid_out,
               halted, retire_count
    );
`else
    modport master (
        output stall, flush, valid_in, PC, ALURes, ReadData, Mem_Read,
               Reg_Write, WriteReg, halt_in,
        input  PCOut, WriteData, WriteRegOut, RegWriteOut, valid_out,
               halted
    );
    modport slave (
        input  stall, flush, valid_in, PC, ALURes, ReadData, Mem_Read,
               Reg_Write, WriteReg, halt_in,
        output PCOut, WriteData, WriteRegOut, RegWriteOut, valid_out,
               halted
    );
`endif
endinterface

// File: rtl/writeback_stage.sv
// WB stage: MEM/WB register, write-back select, r0 guard, halt FSM.
// Optional retired-instruction counter enabled by RETIRE_CNT_EN.
module writeback_stage (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  wb
);
    typedef enum logic {RUN, HALTED} state_t;

    typedef struct packed {
        logic [12:0] pc;
        logic [31:0] wdata;
        logic [4:0]  wreg;
        logic        regwr;
        logic        vld;
    } wb_entry_t;

    state_t    state_q, state_d;
    wb_entry_t entry_q, entry_d;
    logic      capture;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        capture = 1'b0;
        case (state_q)
            RUN: begin
                if (wb.flush) begin
                    entry_d = '0;
                end else if (!wb.stall) begin
                    capture       = 1'b1;
                    entry_d.pc    = wb.PC;
                    entry_d.wdata = wb.Mem_Read ? wb.ReadData : wb.ALURes;
                    entry_d.wreg  = wb.WriteReg;
                    entry_d.vld   = wb.valid_in;
                    // r0 is hardwired zero and HALT never writes back
                    entry_d.regwr = wb.valid_in & wb.Reg_Write &
                                    (wb.WriteReg != 5'd0) & ~wb.halt_in;
                    if (wb.valid_in && wb.halt_in)
                        state_d = HALTED;
                end
            end
            HALTED: begin
                entry_d.vld   = 1'b0;
                entry_d.regwr = 1'b0;
            end
            default: begin
                state_d = RUN;
                entry_d = '0;
            end
        endcase
    end

    assign wb.PCOut       = entry_q.pc;
    assign wb.WriteData   = entry_q.wdata;
    assign wb.WriteRegOut = entry_q.wreg;
    assign wb.RegWriteOut = entry_q.regwr;
    assign wb.valid_out   = entry_q.vld;
    assign wb.halted      = (state_q == HALTED);

`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            retire_cnt_q <= '0;
        else if (capture && wb.valid_in && (retire_cnt_q != 32'hFFFF_FFFF))
            retire_cnt_q <= retire_cnt_q + 32'd1;
    end

    assign wb.retire_count = retire_cnt_q;
`endif
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final (WB) stage of the 5-stage pipeline, fed directly by the memory stage's PCOut / ReadDataOut / ALUOut / Mem_Read_Out outputs. Registers the MEM/WB boundary, selects the write-back value (load data vs ALU result), and drives the register-file write port. It also provides forwarding taps, a halt state machine and an optional retired-instruction counter.

## Interface
Parameters:
- none (widths fixed: PC 13 bits, data 32 bits, register index 5 bits)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  1  hold MEM/WB register contents
- flush  in  1  replace incoming entry with bubble
- valid_in  in  1  incoming entry is a real instruction
- PC  in  13  instruction PC from memory stage
- ALURes  in  32  ALU result from memory stage
- ReadData  in  32  load data from memory stage
- Mem_Read  in  1  1 = write back ReadData, 0 = write back ALURes
- Reg_Write  in  1  instruction writes register file
- WriteReg  in  5  destination register index
- halt_in  in  1  instruction is HALT
- PCOut  out  13  registered PC
- WriteData  out  32  registered selected write-back value
- WriteRegOut  out  5  registered destination index
- RegWriteOut  out  1  register-file write enable
- valid_out  out  1  registered entry valid
- halted  out  1  core halted
- retire_count  out  32  retired instructions (only with RETIRE_CNT_EN)

## Operation
- States: RUN, HALTED. Reset -> RUN.
- RUN, each rising edge, priority order:
  - flush=1: load bubble (valid_out=0, RegWriteOut=0, WriteRegOut=0, WriteData=0, PCOut=0). Flush overrides stall.
  - stall=1: all registers hold; no counting.
  - otherwise: capture PC, WriteData = Mem_Read ? ReadData : ALURes, WriteRegOut = WriteReg, valid_out = valid_in.
  - RegWriteOut = valid_in & Reg_Write & (WriteReg != 0) & ~halt_in; writes to r0 are always suppressed.
  - Captured entry with valid_in=1 and halt_in=1: state -> HALTED, halted=1 on that same edge. The HALT entry shows valid_out=1, RegWriteOut=0.
- HALTED: every input ignored, including flush and stall. On the first edge after entry: valid_out=0, RegWriteOut=0; other data outputs hold. Only rst leaves HALTED.
- halt_in with valid_in=0 is ignored.
- Forwarding: WriteData/WriteRegOut/RegWriteOut are the forwarding taps; consumers qualify with RegWriteOut.

## Timing
- Latency: 1 cycle input-to-output; all outputs are registered, with no combinational input-to-output path.
- Reset (async, rst=0): all outputs 0, state RUN, retire_count 0. Takes effect immediately, mid-stall or mid-halt included.
- Release of rst: first capture occurs on the first rising edge with rst=1.
- Throughput: one entry per cycle when stall=0.
- Simultaneous flush+stall: bubble loaded. Simultaneous flush+halt_in: halt discarded, stays RUN.

## Configuration
- RETIRE_CNT_EN defined:
  - retire_count port exists.
  - Increments by 1 on every edge in RUN where an entry is captured (not stalled, not flushed) with valid_in=1; the HALT instruction is counted.
  - Saturates at 0xFFFFFFFF. Frozen in HALTED.
- RETIRE_CNT_EN undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset: drive rst=0 mid-run with a valid entry registered -> all outputs 0 immediately, before any clock edge; state RUN.
- Select: Mem_Read=1, ReadData=0xDEADBEEF, ALURes=0x12345678, Reg_Write=1, WriteReg=7, valid_in=1 -> next edge WriteData=0xDEADBEEF, WriteRegOut=7, RegWriteOut=1. Repeat with Mem_Read=0 -> WriteData=0x12345678.
- r0 guard: Reg_Write=1, WriteReg=0, valid_in=1 -> RegWriteOut=0, valid_out=1.
- Stall/flush: register PC=0x0A4, then stall=1 for 3 cycles with changing inputs -> outputs hold at PC=0x0A4. Then stall=1 with flush=1 -> bubble: valid_out=0, RegWriteOut=0.
- Halt: valid_in=1, halt_in=1, Reg_Write=1, WriteReg=3 -> same edge halted=1, valid_out=1, RegWriteOut=0. Next edge valid_out=0, and stays 0 for 5 cycles of valid inputs. rst=0 -> halted=0.
- Counter (RETIRE_CNT_EN): 10 valid entries with 2 stalled cycles and 1 flushed cycle interleaved -> retire_count=10. Preloaded counter at 0xFFFFFFFF plus one valid entry -> retire_count stays 0xFFFFFFFF.
